weather_alert_responder: RTL

Cockpit-side responder to the weather/emergency safety unit. It samples that unit's `severe_weather`, `emergency_landing_alert` and 2-bit state outputs, escalates crew alerts, waits a bounded time for pilot acknowledgement, and commands an automatic descent when the crew does not respond or an emergency landing is declared. It sits between the safety unit and the cockpit annunciator and autopilot interfaces.

---
 rtl/weather_alert_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/weather_alert_responder.sv
// Cockpit responder to the weather/emergency safety unit: escalates crew alerts,
// times out unacknowledged warnings into auto-descent and latches emergency descent.
module weather_alert_responder #(
    parameter int ACK_TIMEOUT = 16,
    parameter int HORN_PERIOD = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       severe_weather,
    input  logic       emergency_landing_alert,
    input  logic [1:0] ECSU_state,
    input  logic       pilot_ack,
    input  logic       landed,
    output logic [2:0] resp_state,
    output logic       caution_lamp,
    output logic       warning_horn,
    output logic       descent_cmd,
    output logic [7:0] warn_events
);

    localparam int AW = $clog2(ACK_TIMEOUT);
    localparam int HW = $clog2(HORN_PERIOD + 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [HW-1:0] HORN_LAST = HW'(HORN_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_NORMAL       = 3'd0,
        ST_CAUTION      = 3'd1,
        ST_WARN         = 3'd2,
        ST_WARN_ACK     = 3'd3,
        ST_AUTO_DESCENT = 3'd4,
        ST_EMERGENCY    = 3'd5,
        ST_LANDED       = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ack_q, ack_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            horn_q, horn_d;
    logic            caution_q, caution_d;
    logic            descent_q, descent_d;
    logic [7:0]      ev_q, ev_d;
    logic            emerg;
    state_t          calm_st;

    always_comb begin
        state_d   = ST_NORMAL;
        ack_d     = ack_q;
        hcnt_d    = hcnt_q;
        horn_d    = 1'b0;
        ev_d      = ev_q;
        caution_d = 1'b0;
        descent_d = 1'b0;
        emerg     = emergency_landing_alert || (ECSU_state == 2'd3);
        calm_st   = (ECSU_state == 2'd1) ? ST_CAUTION : ST_NORMAL;

        case (state_q)
            ST_NORMAL, ST_CAUTION: begin
                if (emerg) begin
                    state_d = ST_EMERGENCY;
                end else if (severe_weather) begin
                    state_d = ST_WARN;
                    ack_d   = '0;
                    hcnt_d  = '0;
                    horn_d  = 1'b1;
                    if (ev_q != '1) ev_d = ev_q + 8'd1;
                end else begin
                    state_d = calm_st;
                end
            end
            ST_WARN: begin
                if (emerg) begin
                    state_d = ST_EMERGENCY;
                end else if (!severe_weather) begin
                    state_d = calm_st;
                end else if (pilot_ack) begin
                    state_d = ST_WARN_ACK;
                end else if (ack_q == ACK_LAST) begin
                    state_d = ST_AUTO_DESCENT;
                end else begin
                    state_d = ST_WARN;
                    ack_d   = ack_q + AW'(1);
                    // Horn half-period ends when the counter reaches its last value.
                    if (hcnt_q == HORN_LAST) begin
                        horn_d = ~horn_q;
                        hcnt_d = '0;
                    end else begin
                        horn_d = horn_q;
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
            end
            ST_WARN_ACK: begin
                if (emerg)                state_d = ST_EMERGENCY;
                else if (!severe_weather) state_d = calm_st;
                else                      state_d = ST_WARN_ACK;
            end
            ST_AUTO_DESCENT: begin
                if (landed)     state_d = ST_LANDED;
                else if (emerg) state_d = ST_EMERGENCY;
                else            state_d = ST_AUTO_DESCENT;
            end
            ST_EMERGENCY: state_d = landed ? ST_LANDED : ST_EMERGENCY;
            ST_LANDED:    state_d = ST_LANDED;
            default:      state_d = ST_NORMAL;
        endcase

        // Outputs are registered from the next state so they track resp_state exactly.
        if (state_d == ST_EMERGENCY) horn_d = 1'b1;
        caution_d = (state_d == ST_CAUTION) || (state_d == ST_WARN_ACK);
        descent_d = (state_d == ST_AUTO_DESCENT) || (state_d == ST_EMERGENCY);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_NORMAL;
            ack_q     <= '0;
            hcnt_q    <= '0;
            horn_q    <= 1'b0;
            caution_q <= 1'b0;
            descent_q <= 1'b0;
            ev_q      <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            hcnt_q    <= hcnt_d;
            horn_q    <= horn_d;
            caution_q <= caution_d;
            descent_q <= descent_d;
            ev_q      <= ev_d;
        end
    end

    assign resp_state   = state_q;
    assign caution_lamp = caution_q;
    assign warning_horn = horn_q;
    assign descent_cmd  = descent_q;
    assign warn_events  = ev_q;

endmodule
